// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory read port and the decode-side handshake of the fetch unit.
// Handshake: a word transfers on a cycle where instr_valid and instr_ready are both high; instr_valid never depends on instr_ready.
interface instruction_fetch_if;
  logic [3:0]  mem_address;
  logic        mem_wren;
  logic [15:0] mem_din;
  logic [15:0] mem_q;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic [2:0]  op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [2:0]  rz;
  logic [3:0]  imm4;
  logic [6:0]  imm7;

  modport master (
    output mem_address, mem_wren, mem_din,
    input  mem_q,
    output instr_valid, instr, instr_pc, op, rx, ry, rz, imm4, imm7,
    input  instr_ready
  );

  modport slave (
    input  mem_address, mem_wren, mem_din,
    output mem_q,
    input  instr_valid, instr, instr_pc, op, rx, ry, rz, imm4, imm7,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: issues one PC per cycle into a registered-read instruction memory and
// queues returned words in a 2-entry buffer with credit-based flow control and redirect flush.
module instruction_fetch (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                enable,
  input  logic                redirect_valid,
  input  logic [3:0]          redirect_pc,
  instruction_fetch_if.master bus
);

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 4;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              squash;
  logic [15:0]       buf_word [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic [1:0]        count;
  logic              head;

  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic              tail;
  logic [2:0]        occupancy;

  assign bus.mem_address = pc;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_din     = 16'h0000;

  always_comb begin
    valid     = (count != 2'd0);
    pop       = valid & bus.instr_ready;
    // Redirect wins over the returning word, so a response visible this cycle is dropped.
    push      = inflight & ~squash & ~redirect_valid;
    occupancy = {1'b0, count} + {2'b00, inflight};
    // Only issue when the buffer is guaranteed a free slot when the word returns.
    issue     = enable & ~redirect_valid & (occupancy < (3'd2 + {2'b00, pop}));
    tail      = head ^ count[0];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
      count       <= 2'd0;
      head        <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      squash   <= inflight;
      count    <= 2'd0;
      head     <= 1'b0;
    end else begin
      squash   <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 4'd1;
      end
      head  <= head ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: contents are only visible while count marks them valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      buf_word[tail] <= bus.mem_q;
      buf_pc[tail]   <= inflight_pc;
    end
  end

  always_comb begin
    bus.instr_valid = valid;
    bus.instr       = valid ? buf_word[head] : 16'h0000;
    bus.instr_pc    = valid ? buf_pc[head]   : 4'h0;
    bus.op          = bus.instr[15:13];
    bus.rx          = bus.instr[12:10];
    bus.ry          = bus.instr[9:7];
    bus.rz          = bus.instr[6:4];
    bus.imm4        = bus.instr[3:0];
    bus.imm7        = bus.instr[6:0];
  end

  push_into_full: assert property (@(posedge Clock) disable iff (Reset)
    !(push && count == 2'd2));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table against a registered-read
// memory model, plus a mid-stream reset sequence.
module tb_instruction_fetch;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [3:0] redirect_pc = 4'h0;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master)
  );

  // clock / memory model
  always #5 Clock = ~Clock;

  logic [15:0] prog [16];
  always @(posedge Clock) bus.mem_q <= prog[bus.mem_address];

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rv;
    logic [3:0] rpc;
    logic       ev;
    logic [3:0] epc;
    logic [3:0] eaddr;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  rz;
    logic [3:0]  imm4;
    logic [6:0]  imm7;
  } fld_t;

  localparam int NVEC = 44;
  vec_t vecs [NVEC];
  fld_t flds [4];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv, input logic [3:0] rpc,
                              input logic ev, input logic [3:0] epc, input logic [3:0] eaddr);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [3:0] epc, input logic [3:0] eaddr);
    chk("instr_valid", idx, {31'd0, bus.instr_valid}, {31'd0, ev});
    chk("mem_address", idx, {28'd0, bus.mem_address}, {28'd0, eaddr});
    chk("mem_wren", idx, {31'd0, bus.mem_wren}, 32'd0);
    chk("mem_din", idx, {16'd0, bus.mem_din}, 32'd0);
    if (ev) begin
      chk("instr", idx, {16'd0, bus.instr}, {16'd0, prog[epc]});
      chk("instr_pc", idx, {28'd0, bus.instr_pc}, {28'd0, epc});
      for (int j = 0; j < 4; j++) begin
        if (flds[j].word == prog[epc]) begin
          chk("op", idx, {29'd0, bus.op}, {29'd0, flds[j].op});
          chk("rx", idx, {29'd0, bus.rx}, {29'd0, flds[j].rx});
          chk("ry", idx, {29'd0, bus.ry}, {29'd0, flds[j].ry});
          chk("rz", idx, {29'd0, bus.rz}, {29'd0, flds[j].rz});
          chk("imm4", idx, {28'd0, bus.imm4}, {28'd0, flds[j].imm4});
          chk("imm7", idx, {25'd0, bus.imm7}, {25'd0, flds[j].imm7});
        end
      end
    end else begin
      chk("instr_idle", idx, {16'd0, bus.instr}, 32'd0);
      chk("instr_pc_idle", idx, {28'd0, bus.instr_pc}, 32'd0);
      chk("fields_idle", idx, {9'd0, bus.op, bus.rx, bus.ry, bus.rz, bus.imm4, bus.imm7}, 32'd0);
    end
  endtask

  // driver: inputs change just after the edge, outputs sampled on the falling edge
  task automatic apply(input int idx, input vec_t v);
    @(posedge Clock);
    #1;
    Reset           = 1'b0;
    enable          = v.en;
    bus.instr_ready = v.rdy;
    redirect_valid  = v.rv;
    redirect_pc     = v.rpc;
    @(negedge Clock);
    check_outputs(idx, v.ev, v.epc, v.eaddr);
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 16'h2C00 + 16'(i) * 16'h0011;
    prog[0] = 16'h4280;
    prog[1] = 16'h6000;
    prog[2] = 16'h8081;
    prog[4] = 16'hA081;

    flds[0] = '{16'h4280, 3'd2, 3'd0, 3'd5, 3'd0, 4'd0, 7'd0};
    flds[1] = '{16'h6000, 3'd3, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0};
    flds[2] = '{16'h8081, 3'd4, 3'd0, 3'd1, 3'd0, 4'd1, 7'd1};
    flds[3] = '{16'hA081, 3'd5, 3'd0, 3'd1, 3'd0, 4'd1, 7'd1};

    // startup, 5-cycle stall from cycle 3, resume
    vecs[0] = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 1, 0, 0, 0, 0, 1);
    vecs[2] = mk(1, 1, 0, 0, 1, 0, 2);
    for (int k = 3; k < 8; k++) vecs[k] = mk(1, 0, 0, 0, 1, 1, 3);
    vecs[8] = mk(1, 1, 0, 0, 1, 1, 3);
    vecs[9] = mk(1, 1, 0, 0, 1, 2, 4);
    // steady stream, wraps 15 -> 0
    for (int k = 10; k < 25; k++) vecs[k] = mk(1, 1, 0, 0, 1, 4'(k - 7), 4'(k - 5));
    // redirect to 4 with one buffered, one in flight
    vecs[25] = mk(1, 0, 1, 4, 1, 2, 4);
    vecs[26] = mk(1, 1, 0, 0, 0, 0, 4);
    vecs[27] = mk(1, 1, 0, 0, 0, 0, 5);
    vecs[28] = mk(1, 1, 0, 0, 1, 4, 6);
    vecs[29] = mk(1, 1, 0, 0, 1, 5, 7);
    // fill buffer, then redirect to 9 coincident with a pop
    vecs[30] = mk(1, 0, 0, 0, 1, 6, 8);
    vecs[31] = mk(1, 0, 0, 0, 1, 6, 8);
    vecs[32] = mk(1, 1, 1, 9, 1, 6, 8);
    vecs[33] = mk(1, 1, 0, 0, 0, 0, 9);
    vecs[34] = mk(1, 1, 0, 0, 0, 0, 10);
    vecs[35] = mk(1, 1, 0, 0, 1, 9, 11);
    vecs[36] = mk(1, 1, 0, 0, 1, 10, 12);
    // enable low: drain, pc frozen
    vecs[37] = mk(0, 1, 0, 0, 1, 11, 13);
    vecs[38] = mk(0, 1, 0, 0, 1, 12, 13);
    vecs[39] = mk(0, 1, 0, 0, 0, 0, 13);
    vecs[40] = mk(1, 1, 0, 0, 0, 0, 13);
    vecs[41] = mk(1, 1, 0, 0, 0, 0, 14);
    vecs[42] = mk(1, 1, 0, 0, 1, 13, 15);
    vecs[43] = mk(1, 1, 0, 0, 1, 14, 0);

    // reset block
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_outputs(-1, 1'b0, 4'd0, 4'd0);

    for (int i = 0; i < NVEC; i++) apply(i, vecs[i]);

    // mid-stream reset: head pc15 buffered, pc0 in flight
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(negedge Clock);
    check_outputs(100, 1'b1, 4'd15, 4'd1);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check_outputs(101, 1'b0, 4'd0, 4'd0);
    @(negedge Clock);
    check_outputs(102, 1'b0, 4'd0, 4'd1);
    @(negedge Clock);
    check_outputs(103, 1'b1, 4'd0, 4'd2);
    @(negedge Clock);
    check_outputs(104, 1'b1, 4'd1, 4'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
